one2eight_demux: RTL

ONE2EIGHT_DEMUX -- requirements
Module: one2eight_demux

---
 rtl/one2eight_demux.sv | 138 +++++++++++++
 1 files changed

// File: rtl/one2eight_demux.sv
`default_nettype none
// ============================================================================
// Module   : one2eight_demux
// Brief    : Routes a serial bit to one of eight registered outputs and
//            assembles each complete set of eight writes into a byte.
// Revision : 1.0
// ============================================================================
module one2eight_demux (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       sel1,
    input  logic       sel2,
    input  logic       sel3,
    input  logic       in_valid,
    input  logic       auto_mode,
    input  logic       clr_ovr,
    output logic       o0,
    output logic       o1,
    output logic       o2,
    output logic       o3,
    output logic       o4,
    output logic       o5,
    output logic       o6,
    output logic       o7,
    output logic [7:0] out_byte,
    output logic       frame_valid,
    output logic       overrun,
    output logic [7:0] frame_cnt
);

    localparam logic [7:0] c_FULL_MASK = 8'hFF;

    logic [7:0] o_q, o_d;
    logic [7:0] out_byte_q, out_byte_d;
    logic       frame_valid_q, frame_valid_d;
    logic       overrun_q, overrun_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [2:0] addr_cnt_q, addr_cnt_d;
    logic [7:0] mask_q, mask_d;
    logic       auto_q;
    logic       primed_q;

    logic       w_mode_chg;
    logic       w_wr;
    logic       w_dup;
    logic       w_complete;
    logic [2:0] w_addr;
    logic [7:0] w_addr_oh;
    logic [7:0] w_mask_upd;

    // The registered mode copy is meaningless on the first edge after reset,
    // so a mode change is only recognised once a non-reset edge has passed.
    always_comb begin
        w_mode_chg = primed_q && (auto_mode != auto_q);
        w_addr     = auto_mode ? addr_cnt_q : {sel3, sel2, sel1};
        w_addr_oh  = 8'd1 << w_addr;
        w_wr       = in_valid && !w_mode_chg;
        w_dup      = w_wr && ((mask_q & w_addr_oh) != 8'd0);
        w_mask_upd = mask_q | w_addr_oh;
        w_complete = w_wr && !w_dup && (w_mask_upd == c_FULL_MASK);
    end

    always_comb begin
        o_d           = o_q;
        out_byte_d    = out_byte_q;
        frame_valid_d = 1'b0;
        overrun_d     = overrun_q;
        frame_cnt_d   = frame_cnt_q;
        addr_cnt_d    = addr_cnt_q;
        mask_d        = mask_q;

        if (w_wr) begin
            o_d = (o_q & ~w_addr_oh) | ({8{din}} & w_addr_oh);
            if (auto_mode) begin
                addr_cnt_d = addr_cnt_q + 3'd1;
            end
        end

        if (w_mode_chg) begin
            mask_d     = 8'd0;
            addr_cnt_d = 3'd0;
        end else if (w_complete) begin
            out_byte_d    = o_d;
            frame_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 8'd1;
            mask_d        = 8'd0;
        end else if (w_wr && !w_dup) begin
            mask_d = w_mask_upd;
        end

        // A new overrun event beats a simultaneous clear.
        if (w_dup) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q           <= 8'd0;
            out_byte_q    <= 8'd0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            frame_cnt_q   <= 8'd0;
            addr_cnt_q    <= 3'd0;
            mask_q        <= 8'd0;
            auto_q        <= 1'b0;
            primed_q      <= 1'b0;
        end else begin
            o_q           <= o_d;
            out_byte_q    <= out_byte_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            frame_cnt_q   <= frame_cnt_d;
            addr_cnt_q    <= addr_cnt_d;
            mask_q        <= mask_d;
            auto_q        <= auto_mode;
            primed_q      <= 1'b1;
        end
    end

    assign o0          = o_q[0];
    assign o1          = o_q[1];
    assign o2          = o_q[2];
    assign o3          = o_q[3];
    assign o4          = o_q[4];
    assign o5          = o_q[5];
    assign o6          = o_q[6];
    assign o7          = o_q[7];
    assign out_byte    = out_byte_q;
    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire
